calendar_clock_core: RTL
========================

Name: calendar_clock_core

Overview:
- Parametrised single-clock calendar timekeeper: keeps seconds, minutes, hours, day, month and year in one synchronous datapath.
- Full Gregorian leap-year rules (div 4, not 100, unless 400).
- Internal configurable 1 Hz divider, field-select set mode with up/down edge detection, and day clamping on month/year edits.
- Feeds the existing BCD/7-segment display path through binary field outputs.

Parameters:
- CLK_HZ, 50_000_000, input clock frequency; one tick every CLK_HZ cycles (benches use 4).
- YEAR_W, 14, year field width; must hold YEAR_MAX.
- YEAR_RESET, 2000, year loaded at reset.
- YEAR_MIN, 0, lowest year; wrap target.
- YEAR_MAX, 9999, highest year; wrap source.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- mode  in  3  0=run, 1=set sec, 2=set min, 3=set hour, 4=set day, 5=set month, 6=set year, 7=hold.
- btn_up  in  1  synchronous level, increment request.
- btn_down  in  1  synchronous level, decrement request.
- sec  out  6  0-59.
- min  out  6  0-59.
- hour  out  5  0-23.
- day  out  5  1-28/29/30/31.
- mont  out  4  1-12.
- year  out  YEAR_W  YEAR_MIN..YEAR_MAX.
- leap  out  1  combinational leap flag of current year.
- tick_1hz  out  1  one-cycle pulse on each run-mode advance.

Behaviour:
- Reset (async, rst=1): sec=0, min=0, hour=0, day=1, mont=1, year=YEAR_RESET, tick_1hz=0, divider=0, button history regs=0. Release is synchronous to the next clk edge.
- Divider:
  - Counts 0..CLK_HZ-1 only while mode==0.
  - At count CLK_HZ-1 it wraps to 0, tick_1hz=1 for that cycle, and the fields advance on the same edge.
  - Divider is held at 0 while mode!=0, so after re-entering run the first tick comes CLK_HZ cycles later.
- Run advance (tick):
  - sec++.
  - sec 59->0 carries to min; min 59->0 carries to hour; hour 23->0 carries to day.
  - day == month_len -> day=1 and carries to mont.
  - mont 12->1 carries to year.
  - year==YEAR_MAX -> YEAR_MIN.
  - All carries resolve in one edge.
- month_len: 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; Feb is 29 if leap, else 28.
- leap = (year%4==0 && year%100!=0) || year%400==0. YEAR_MIN=0 counts as leap.
- Button edge detect:
  - Registered history btn_up_d/btn_down_d.
  - up_ev = btn_up & ~btn_up_d; down_ev likewise.
  - up_ev and down_ev in the same cycle -> both ignored.
  - Held buttons produce one event only (no auto-repeat).
- Set modes 1-6: no time advance.
  - An event modifies only the selected field, updated on the edge where the event is detected (visible next cycle). No carry into other fields.
  - sec/min wrap 59<->0; hour wraps 23<->0; mont wraps 12<->1; year wraps YEAR_MAX<->YEAR_MIN.
  - day wraps month_len<->1 using current mont/year.
- Clamp: on any mont or year edit (or wrap), if day > new month_len then day = new month_len on the same edge. Example: 31 Jan -> Feb in a leap year gives day 29.
- mode 7 (hold): fields frozen, events ignored, tick_1hz=0.
- Events in mode 0 are ignored.
- A mode change mid-cycle takes effect on the next edge; no partial updates.
- Reset asserted mid-edit aborts the edit; all fields take reset values immediately.
- No illegal field value is ever reachable.

Test Plan:
- Reset (CLK_HZ=4) -> 00:00:00 01/01/2000, leap=1, tick_1hz=0; after release in mode 0, first tick_1hz on the 4th edge, sec=1.
- Set 23:59:59 31/12/2099, mode 0 -> after 4 cycles 00:00:00 01/01/2100, leap=0, single tick_1hz pulse.
- 23:59:59 28/02/2000 tick -> 29/02/2000. Same time on 28/02/2100 -> 01/03/2100. Same time on 29/02/2000 -> 01/03/2000.
- mode 4 day=31, mont=1, year 2000; mode 5 btn_up -> mont=2, day=29. mode 6 btn_up (2001) -> day=28. mode 5 btn_down from mont=1 -> mont=12, day unchanged.
- mode 6 year=9999 btn_up -> 0 and btn_down -> 9999. Run from 23:59:59 31/12/9999 -> 00:00:00 01/01/0000.
- Edge cases:
  - btn_up held 10 cycles in mode 1 -> sec +1 only.
  - btn_up and btn_down rising together -> no change.
  - mode 7 for 12 cycles -> no change, no tick.
  - rst pulsed mid-set -> immediate reset values without waiting for a clk edge.

Source files
------------

// File: rtl/calendar_clock_core_if.sv
// Bundle of mode/button inputs and binary calendar field outputs for calendar_clock_core.
// The core drives the slave side; display logic or a bench drives the master side.
interface calendar_clock_core_if #(
    parameter int YEAR_W = 14
);
    logic [2:0]        mode;
    logic              btn_up;
    logic              btn_down;
    logic [5:0]        sec;
    logic [5:0]        min;
    logic [4:0]        hour;
    logic [4:0]        day;
    logic [3:0]        mont;
    logic [YEAR_W-1:0] year;
    logic              leap;
    logic              tick_1hz;

    modport master (
        output mode, btn_up, btn_down,
        input  sec, min, hour, day, mont, year, leap, tick_1hz
    );

    modport slave (
        input  mode, btn_up, btn_down,
        output sec, min, hour, day, mont, year, leap, tick_1hz
    );
endinterface

// File: rtl/calendar_clock_core.sv
// Gregorian calendar timekeeper with 1 Hz divider and button-driven field set mode.
// Fields update on the edge that sees a tick or button event; no backpressure.
module calendar_clock_core #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int YEAR_W     = 14,
    parameter int YEAR_RESET = 2000,
    parameter int YEAR_MIN   = 0,
    parameter int YEAR_MAX   = 9999
) (
    input  logic                  clk,
    input  logic                  rst,
    calendar_clock_core_if.slave  bus
);
    localparam int DIV_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_HZ - 1);
    localparam logic [YEAR_W-1:0] Y_MIN    = YEAR_W'(YEAR_MIN);
    localparam logic [YEAR_W-1:0] Y_MAX    = YEAR_W'(YEAR_MAX);
    localparam logic [YEAR_W-1:0] Y_RST    = YEAR_W'(YEAR_RESET);

    typedef enum logic [2:0] {
        MODE_RUN  = 3'd0, MODE_SEC  = 3'd1, MODE_MIN  = 3'd2, MODE_HOUR = 3'd3,
        MODE_DAY  = 3'd4, MODE_MONT = 3'd5, MODE_YEAR = 3'd6, MODE_HOLD = 3'd7
    } mode_e;

    function automatic logic is_leap(input logic [YEAR_W-1:0] y);
        int yi;
        yi = int'(y);
        return ((yi % 4 == 0) && (yi % 100 != 0)) || (yi % 400 == 0);
    endfunction

    function automatic logic [4:0] month_len(input logic [3:0] m, input logic lp);
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: return 5'd30;
            4'd2:                    return lp ? 5'd29 : 5'd28;
            default:                 return 5'd31;
        endcase
    endfunction

    logic [DIV_W-1:0]  div_q, div_n;
    logic [5:0]        sec_q, sec_n, min_q, min_n;
    logic [4:0]        hour_q, hour_n, day_q, day_n;
    logic [3:0]        mont_q, mont_n;
    logic [YEAR_W-1:0] year_q, year_n;
    logic              tick_q, tick_n;
    logic              btn_up_d, btn_down_d;
    logic              up_ev, down_ev;
    logic              leap_cur;
    logic [4:0]        len_cur, len_new;

    assign leap_cur = is_leap(year_q);
    assign len_cur  = month_len(mont_q, leap_cur);
    // Simultaneous rising edges cancel each other out.
    assign up_ev    = bus.btn_up & ~btn_up_d & ~(bus.btn_down & ~btn_down_d);
    assign down_ev  = bus.btn_down & ~btn_down_d & ~(bus.btn_up & ~btn_up_d);

    always_comb begin
        div_n   = '0;
        sec_n   = sec_q;
        min_n   = min_q;
        hour_n  = hour_q;
        day_n   = day_q;
        mont_n  = mont_q;
        year_n  = year_q;
        tick_n  = 1'b0;
        len_new = len_cur;
        case (mode_e'(bus.mode))
            MODE_RUN: begin
                if (div_q == DIV_LAST) begin
                    tick_n = 1'b1;
                    if (sec_q != 6'd59) sec_n = sec_q + 6'd1;
                    else begin
                        sec_n = '0;
                        if (min_q != 6'd59) min_n = min_q + 6'd1;
                        else begin
                            min_n = '0;
                            if (hour_q != 5'd23) hour_n = hour_q + 5'd1;
                            else begin
                                hour_n = '0;
                                if (day_q != len_cur) day_n = day_q + 5'd1;
                                else begin
                                    day_n = 5'd1;
                                    if (mont_q != 4'd12) mont_n = mont_q + 4'd1;
                                    else begin
                                        mont_n = 4'd1;
                                        year_n = (year_q == Y_MAX) ? Y_MIN : year_q + YEAR_W'(1);
                                    end
                                end
                            end
                        end
                    end
                end else begin
                    div_n = div_q + DIV_W'(1);
                end
            end
            MODE_SEC: begin
                if (up_ev)   sec_n = (sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1;
                if (down_ev) sec_n = (sec_q == 6'd0) ? 6'd59 : sec_q - 6'd1;
            end
            MODE_MIN: begin
                if (up_ev)   min_n = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
                if (down_ev) min_n = (min_q == 6'd0) ? 6'd59 : min_q - 6'd1;
            end
            MODE_HOUR: begin
                if (up_ev)   hour_n = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                if (down_ev) hour_n = (hour_q == 5'd0) ? 5'd23 : hour_q - 5'd1;
            end
            MODE_DAY: begin
                if (up_ev)   day_n = (day_q >= len_cur) ? 5'd1 : day_q + 5'd1;
                if (down_ev) day_n = (day_q <= 5'd1) ? len_cur : day_q - 5'd1;
            end
            MODE_MONT: begin
                if (up_ev)   mont_n = (mont_q == 4'd12) ? 4'd1 : mont_q + 4'd1;
                if (down_ev) mont_n = (mont_q == 4'd1) ? 4'd12 : mont_q - 4'd1;
                len_new = month_len(mont_n, leap_cur);
                if (day_q > len_new) day_n = len_new;
            end
            MODE_YEAR: begin
                if (up_ev)   year_n = (year_q == Y_MAX) ? Y_MIN : year_q + YEAR_W'(1);
                if (down_ev) year_n = (year_q == Y_MIN) ? Y_MAX : year_q - YEAR_W'(1);
                len_new = month_len(mont_q, is_leap(year_n));
                if (day_q > len_new) day_n = len_new;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q      <= '0;
            sec_q      <= '0;
            min_q      <= '0;
            hour_q     <= '0;
            day_q      <= 5'd1;
            mont_q     <= 4'd1;
            year_q     <= Y_RST;
            tick_q     <= 1'b0;
            btn_up_d   <= 1'b0;
            btn_down_d <= 1'b0;
        end else begin
            div_q      <= div_n;
            sec_q      <= sec_n;
            min_q      <= min_n;
            hour_q     <= hour_n;
            day_q      <= day_n;
            mont_q     <= mont_n;
            year_q     <= year_n;
            tick_q     <= tick_n;
            btn_up_d   <= bus.btn_up;
            btn_down_d <= bus.btn_down;
        end
    end

    assign bus.sec      = sec_q;
    assign bus.min      = min_q;
    assign bus.hour     = hour_q;
    assign bus.day      = day_q;
    assign bus.mont     = mont_q;
    assign bus.year     = year_q;
    assign bus.leap     = leap_cur;
    assign bus.tick_1hz = tick_q;
endmodule
